// File: rtl/pc_run_reg.sv
// Program-counter register with load/increment/hold and a BOOT/RUN/HALT control FSM.
// Optional sticky overflow flag output ovf when PC_STICKY_OVF_EN is defined.
module pc_run_reg #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RESET_VEC = 0,
  parameter int unsigned STEP      = 1
) (
  input  logic             clk,
  input  logic             clrbar,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  input  logic             inc,
  input  logic             halt,
  input  logic             resume,
  output logic [WIDTH-1:0] pc,
  output logic             running,
`ifdef PC_STICKY_OVF_EN
  output logic             ovf,
`endif
  output logic             wrap
);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VEC);
  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

  state_t         state;
  logic           boot_seen;
  logic [WIDTH:0] inc_sum;

  // Extra top bit captures the carry out of bit WIDTH-1.
  assign inc_sum = {1'b0, pc} + {1'b0, STEP_V};

  // BOOT spends the first post-reset edge arming, and leaves for RUN on the next.
  always_ff @(posedge clk or negedge clrbar) begin
    if (!clrbar) begin
      state     <= BOOT;
      boot_seen <= 1'b0;
      pc        <= RST_PC;
      running   <= 1'b0;
      wrap      <= 1'b0;
`ifdef PC_STICKY_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      wrap <= 1'b0;
      case (state)
        BOOT: begin
          pc        <= RST_PC;
          boot_seen <= 1'b1;
          if (boot_seen) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (halt) begin
            state   <= HALT;
            running <= 1'b0;
          end else if (ld) begin
            pc <= din;
`ifdef PC_STICKY_OVF_EN
            ovf <= 1'b0;
`endif
          end else if (inc) begin
            pc   <= inc_sum[WIDTH-1:0];
            wrap <= inc_sum[WIDTH];
`ifdef PC_STICKY_OVF_EN
            if (inc_sum[WIDTH]) ovf <= 1'b1;
`endif
          end
        end
        HALT: begin
          if (ld) begin
            pc <= din;
`ifdef PC_STICKY_OVF_EN
            ovf <= 1'b0;
`endif
          end
          if (resume && !halt) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state   <= BOOT;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule
